// File: rtl/regfile_dump_pkg.sv
// Shared types and constants for the register-file dump engine.
package regfile_dump_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic DUMP_ALL     = 1'b0;
  localparam logic DUMP_CHANGED = 1'b1;

endpackage

// File: rtl/regfile_dump_unit_lowest_set_index.sv
// Combinational priority encoder: index of the lowest set bit of a mask.
module lowest_set_index
  import regfile_dump_pkg::*;
#(
  parameter int unsigned N  = 32,
  parameter int unsigned AW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  output logic [AW-1:0] idx,
  output logic          none
);

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    idx  = '0;
    none = 1'b1;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx  = AW'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_dump_unit.sv
// Register-file dump engine: tracks written registers and streams a
// snapshot (all or changed-only) over a valid/ready port.
module regfile_dump_unit
  import regfile_dump_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = $clog2(NREG),
  parameter int unsigned TW   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            trigger,
  input  logic            mode,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW-1:0]   out_addr,
  output logic [XLEN-1:0] out_data,
  output logic [TW-1:0]   out_time,
  output logic            out_last,
  output logic            busy,
  output logic            done
);

  state_t          state;
  logic [TW-1:0]   cyc;
  logic [NREG-1:0] dirty;
  logic [NREG-1:0] snap;
  logic [NREG-1:0] dirty_set;
  logic [NREG-1:0] snap_trig;
  logic [NREG-1:0] snap_clr;
  logic [NREG-1:0] enc_mask;
  logic [AW-1:0]   idx;
  logic [AW-1:0]   enc_idx;
  logic            enc_none;
  logic            bypass;

  // One-hot of the register written back this cycle; x0 never counts.
  always_comb begin
    dirty_set = '0;
    if (wb_en && (wb_addr != '0) && (32'(wb_addr) < NREG)) begin
      dirty_set[wb_addr] = 1'b1;
    end
  end

  // Snapshot remaining after the current index is sent.
  always_comb begin
    snap_clr      = snap;
    snap_clr[idx] = 1'b0;
  end

  assign snap_trig = (mode == DUMP_CHANGED) ? dirty : '1;
  // Encoder looks at the trigger-time snapshot in IDLE, the live snap otherwise.
  assign enc_mask  = (state == IDLE) ? snap_trig : snap;
  assign rd_addr   = (state == LOAD) ? idx : '0;
  assign bypass    = wb_en && (wb_addr == idx) && (idx != '0);

  lowest_set_index #(
    .N  (NREG),
    .AW (AW)
  ) u_lsi (
    .mask (enc_mask),
    .idx  (enc_idx),
    .none (enc_none)
  );

  // Free-running cycle counter used as the dump timestamp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + TW'(1);
  end

  // Live dirty mask; cleared at an accepted trigger except for a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         dirty <= '0;
    else if ((state == IDLE) && trigger) dirty <= dirty_set;
    else                                 dirty <= dirty | dirty_set;
  end

  // Dump sequencer with registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      snap      <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_time  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            snap     <= snap_trig;
            out_time <= cyc;
            busy     <= 1'b1;
            if (enc_none) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              idx   <= enc_idx;
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          out_data  <= bypass ? wb_data : rd_data;
          out_addr  <= idx;
          out_last  <= (snap_clr == '0);
          snap      <= snap_clr;
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              idx   <= enc_idx;
              state <= LOAD;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Directed self-checking bench for regfile_dump_unit.
module tb_regfile_dump_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trigger = 1'b0;
  logic        mode = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic [31:0] out_time;
  logic        out_last;
  logic        busy;
  logic        done;

  // Small instance with a 4-bit timestamp to exercise counter wrap.
  logic        s_trigger = 1'b0;
  logic [1:0]  s_rd_addr;
  logic [7:0]  s_rd_data = 8'hA5;
  logic        s_out_valid;
  logic [1:0]  s_out_addr;
  logic [7:0]  s_out_data;
  logic [3:0]  s_out_time;
  logic        s_out_last;
  logic        s_busy;
  logic        s_done;

  int errors = 0;
  int checks = 0;

  logic [31:0] rf [32];
  logic [31:0] tb_cyc;

  logic [4:0]  q_addr [$];
  logic [31:0] q_data [$];
  logic        q_last [$];
  logic [31:0] q_time [$];
  int          done_n;
  logic [4:0]  load_rd;
  logic [31:0] trig_cyc;

  always #5 clk = ~clk;

  regfile_dump_unit dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .mode(mode),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_time(out_time), .out_last(out_last),
    .busy(busy), .done(done)
  );

  regfile_dump_unit #(.XLEN(8), .NREG(4), .TW(4)) u_small (
    .clk(clk), .rst_n(rst_n), .trigger(s_trigger), .mode(1'b0),
    .wb_en(1'b0), .wb_addr(2'd0), .wb_data(8'd0),
    .rd_addr(s_rd_addr), .rd_data(s_rd_data),
    .out_valid(s_out_valid), .out_ready(1'b1), .out_addr(s_out_addr),
    .out_data(s_out_data), .out_time(s_out_time), .out_last(s_out_last),
    .busy(s_busy), .done(s_done)
  );

  // Register-file model; x0 reads as zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      rf[wb_addr] <= wb_data;
    end
  end
  assign rd_data = rf[rd_addr];

  // Reference cycle count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= '0;
    else        tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic chk_beat(input int k, input logic [4:0] a, input logic [31:0] d, input logic l);
    if (k < q_addr.size()) begin
      chk($sformatf("beat%0d_addr", k), 64'(q_addr[k]), 64'(a));
      chk($sformatf("beat%0d_data", k), 64'(q_data[k]), 64'(d));
      chk($sformatf("beat%0d_last", k), 64'(q_last[k]), 64'(l));
      chk($sformatf("beat%0d_time", k), 64'(q_time[k]), 64'(trig_cyc));
    end else begin
      chk($sformatf("beat%0d_present", k), 64'(q_addr.size()), 64'(k + 1));
    end
  endtask

  // Trigger a dump and collect beats until done; returns one cycle later in IDLE.
  task automatic run_dump(input logic m, input bit toggle, input bit inject, input bit retrig);
    logic [63:0] hold_val;
    bit held;
    q_addr.delete(); q_data.delete(); q_last.delete(); q_time.delete();
    done_n   = -1;
    load_rd  = '0;
    held     = 1'b0;
    hold_val = '0;
    trig_cyc = tb_cyc;
    trigger  = 1'b1;
    mode     = m;
    tick();
    trigger  = 1'b0;
    mode     = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      out_ready = toggle ? ((n % 4 == 1) || (n % 4 == 0)) : 1'b1;
      wb_en     = 1'b0;
      trigger   = 1'b0;
      if (inject && (n == 1)) begin
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hCAFE_F00D;
      end
      if (retrig && (n == 3)) begin
        trigger = 1'b1; mode = 1'b1;
      end
      if (n == 1) load_rd = rd_addr;
      if (held) chk("hold_stable", 64'({out_valid, out_addr, out_last, out_data}), hold_val);
      held     = out_valid && !out_ready;
      hold_val = 64'({out_valid, out_addr, out_last, out_data});
      if (out_valid && out_ready) begin
        q_addr.push_back(out_addr);
        q_data.push_back(out_data);
        q_last.push_back(out_last);
        q_time.push_back(out_time);
      end
      if (done) begin
        done_n = n;
        break;
      end
      tick();
    end
    wb_en = 1'b0; trigger = 1'b0; mode = 1'b0; out_ready = 1'b1;
    if (done_n < 0) chk("done_timeout", 64'(done_n), 64'd1);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_done",      64'(done),      64'd0);
    chk("rst_out_last",  64'(out_last),  64'd0);
    chk("rst_out_addr",  64'(out_addr),  64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_time",  64'(out_time),  64'd0);
    chk("rst_rd_addr",   64'(rd_addr),   64'd0);
    rst_n = 1'b1;
    tick();

    // Preload x1..x31 and dump everything
    for (int i = 1; i < 32; i++) wb_write(5'(i), 32'h1000 + 32'(i));
    run_dump(1'b0, 1'b0, 1'b0, 1'b0);
    chk("all_count", 64'(q_addr.size()), 64'd32);
    chk("all_done_cycle", 64'(done_n), 64'd65);
    for (int i = 0; i < 32; i++)
      chk_beat(i, 5'(i), (i == 0) ? 32'h0 : 32'h1000 + 32'(i), i == 31);
    chk("idle_rd_addr", 64'(rd_addr), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // Changed-only dump, then an immediate empty one
    wb_write(5'd5, 32'hDEAD_BEEF);
    wb_write(5'd17, 32'h1234_5678);
    wb_write(5'd0, 32'hFFFF_FFFF);
    run_dump(1'b1, 1'b0, 1'b0, 1'b0);
    chk("chg_count", 64'(q_addr.size()), 64'd2);
    chk_beat(0, 5'd5, 32'hDEAD_BEEF, 1'b0);
    chk_beat(1, 5'd17, 32'h1234_5678, 1'b1);
    run_dump(1'b1, 1'b0, 1'b0, 1'b0);
    chk("empty_count", 64'(q_addr.size()), 64'd0);
    chk("empty_done_cycle", 64'(done_n), 64'd1);

    // Back-pressure with ready toggling 1-0-0-1
    wb_write(5'd3, 32'h0000_0033);
    wb_write(5'd9, 32'h0000_0099);
    wb_write(5'd7, 32'h0000_0077);
    run_dump(1'b1, 1'b1, 1'b0, 1'b0);
    chk("bp_count", 64'(q_addr.size()), 64'd3);
    chk_beat(0, 5'd3, 32'h33, 1'b0);
    chk_beat(1, 5'd7, 32'h77, 1'b0);
    chk_beat(2, 5'd9, 32'h99, 1'b1);

    // Write-back bypass during LOAD of x5
    wb_write(5'd5, 32'h0000_5555);
    run_dump(1'b1, 1'b0, 1'b1, 1'b0);
    chk("byp_rd_addr", 64'(load_rd), 64'd5);
    chk("byp_count", 64'(q_addr.size()), 64'd1);
    chk_beat(0, 5'd5, 32'hCAFE_F00D, 1'b1);
    run_dump(1'b1, 1'b0, 1'b0, 1'b0);
    chk("byp_redirty_count", 64'(q_addr.size()), 64'd1);
    chk_beat(0, 5'd5, 32'hCAFE_F00D, 1'b1);

    // Trigger while busy is ignored
    run_dump(1'b0, 1'b0, 1'b0, 1'b1);
    chk("retrig_count", 64'(q_addr.size()), 64'd32);
    chk("retrig_done_cycle", 64'(done_n), 64'd65);
    chk_beat(31, 5'd31, 32'h101F, 1'b1);
    chk_beat(5, 5'd5, 32'hCAFE_F00D, 1'b0);

    // Timestamp at all-ones, then wrapped value (4-bit counter instance)
    for (int i = 0; (i < 16) && (tb_cyc[3:0] != 4'hF); i++) tick();
    s_trigger = 1'b1;
    tick();
    s_trigger = 1'b0;
    chk("wrap_time_max", 64'(s_out_time), 64'hF);
    chk("wrap_busy", 64'(s_busy), 64'd1);
    for (int i = 0; (i < 20) && !s_done; i++) tick();
    chk("wrap_done", 64'(s_done), 64'd1);
    tick();
    s_trigger = 1'b1;
    tick();
    s_trigger = 1'b0;
    chk("wrap_time_small", 64'(s_out_time), 64'd9);
    for (int i = 0; (i < 20) && !s_done; i++) tick();
    tick();

    // Reset during SEND of the third beat
    wb_write(5'd4, 32'h0000_0044);
    trigger = 1'b1; mode = 1'b0;
    tick();
    trigger = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_addr", 64'(out_addr), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_addr", 64'(out_addr), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_dump(1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_rst_count", 64'(q_addr.size()), 64'd0);
    chk("post_rst_done_cycle", 64'(done_n), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
